// File: rtl/word_round_sequencer.sv
// Round sequencer for the typing game: start screen, per-letter matching, per-word
// countdown, score/lives bookkeeping and game over.
`timescale 1ns/1ps
module word_round_sequencer #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int WORD_TIME_S   = 5,
  parameter int MAX_LIVES     = 3
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic        start,
  input  logic        key_valid,
  input  logic [4:0]  key_char,
  input  logic [19:0] target_word,
  output logic        word_req,
  output logic [3:0]  word_pos,
  output logic [7:0]  score,
  output logic [1:0]  lives,
  output logic [3:0]  time_left
);

  localparam int             PW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0]  PRE_MAX    = PW'(TICKS_PER_SEC - 1);
  localparam logic [3:0]     TIME_INIT  = 4'(WORD_TIME_S);
  localparam logic [1:0]     LIVES_INIT = 2'(MAX_LIVES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  state_t         r_state,     w_state_nx;
  logic [1:0]     r_index,     w_index_nx;
  logic [7:0]     r_score,     w_score_nx;
  logic [1:0]     r_lives,     w_lives_nx;
  logic [3:0]     r_time_left, w_time_nx;
  logic [PW-1:0]  r_prescaler, w_pre_nx;
  logic           r_word_req,  w_req_nx;
  logic [3:0]     r_word_pos,  w_pos_nx;

  logic [4:0]     w_letter;
  logic           w_hit;
  logic           w_tick;
  logic           w_timeout;

  always_comb begin
    unique case (r_index)
      2'd0:    w_letter = target_word[19:15];
      2'd1:    w_letter = target_word[14:10];
      2'd2:    w_letter = target_word[9:5];
      default: w_letter = target_word[4:0];
    endcase
  end

  assign w_hit     = key_valid && (key_char == w_letter);
  assign w_tick    = (r_prescaler == PRE_MAX);
  assign w_timeout = w_tick && (r_time_left == 4'd1);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path can infer a latch.
    w_state_nx = r_state;
    w_index_nx = r_index;
    w_score_nx = r_score;
    w_lives_nx = r_lives;
    w_time_nx  = r_time_left;
    w_pre_nx   = r_prescaler;
    w_req_nx   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx = S_PLAY;
          w_score_nx = '0;
          w_lives_nx = LIVES_INIT;
          w_index_nx = '0;
          w_time_nx  = TIME_INIT;
          w_pre_nx   = '0;
          w_req_nx   = 1'b1;
        end
      end

      S_PLAY: begin
        w_pre_nx = w_tick ? '0 : r_prescaler + PW'(1);
        // A zero on time_left is the one-cycle timeout display; reload after it.
        if (r_time_left == 4'd0) begin
          w_time_nx = TIME_INIT;
        end else if (w_tick) begin
          w_time_nx = r_time_left - 4'd1;
        end

        if (w_timeout) begin
          w_lives_nx = r_lives - 2'd1;
          w_index_nx = '0;
          w_time_nx  = 4'd0;
          if (r_lives == 2'd1) begin
            w_state_nx = S_OVER;
          end else begin
            w_pre_nx = '0;
            w_req_nx = 1'b1;
          end
        end else if (key_valid) begin
          if (w_hit) begin
            if (r_index != 2'd3) begin
              w_index_nx = r_index + 2'd1;
            end else begin
              w_score_nx = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
              w_index_nx = '0;
              w_time_nx  = TIME_INIT;
              w_pre_nx   = '0;
              w_req_nx   = 1'b1;
            end
          end else begin
            w_lives_nx = r_lives - 2'd1;
            w_index_nx = '0;
            if (r_lives == 2'd1) w_state_nx = S_OVER;
          end
        end
      end

      S_OVER: begin
        if (start) w_state_nx = S_IDLE;
      end

      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    unique case (w_state_nx)
      S_PLAY:  w_pos_nx = {2'b00, w_index_nx};
      S_OVER:  w_pos_nx = 4'd4;
      default: w_pos_nx = 4'd5;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_index     <= '0;
      r_score     <= '0;
      r_lives     <= LIVES_INIT;
      r_time_left <= TIME_INIT;
      r_prescaler <= '0;
      r_word_req  <= 1'b0;
      r_word_pos  <= 4'd5;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state     <= w_state_nx;
      r_index     <= w_index_nx;
      r_score     <= w_score_nx;
      r_lives     <= w_lives_nx;
      r_time_left <= w_time_nx;
      r_prescaler <= w_pre_nx;
      r_word_req  <= w_req_nx;
      r_word_pos  <= w_pos_nx;
    end
  end

  assign word_req  = r_word_req;
  assign word_pos  = r_word_pos;
  assign score     = r_score;
  assign lives     = r_lives;
  assign time_left = r_time_left;

endmodule

// File: tb/tb_word_round_sequencer.sv
// Scoreboard bench for word_round_sequencer: directed round scenarios followed by
// randomized play, checked against a cycle-level reference model.
`timescale 1ns/1ps
module tb_word_round_sequencer;

  localparam int T  = 10;
  localparam int WT = 3;
  localparam int ML = 3;

  localparam int KEY_HIT  = 100;
  localparam int KEY_MISS = 200;

  localparam int PH_IDLE = 0;
  localparam int PH_PLAY = 1;
  localparam int PH_OVER = 2;

  localparam logic [19:0] CATS = {5'd2, 5'd0, 5'd19, 5'd18};

  typedef struct {
    bit req;
    int pos;
    int score;
    int lives;
    int tl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        key_valid = 1'b0;
  logic [4:0]  key_char = '0;
  logic [19:0] target_word = '0;
  logic        word_req;
  logic [3:0]  word_pos;
  logic [7:0]  score;
  logic [1:0]  lives;
  logic [3:0]  time_left;

  word_round_sequencer #(
    .TICKS_PER_SEC(T),
    .WORD_TIME_S  (WT),
    .MAX_LIVES    (ML)
  ) dut (
    .CLK100MHZ  (clk),
    .reset      (rst_n),
    .start      (start),
    .key_valid  (key_valid),
    .key_char   (key_char),
    .target_word(target_word),
    .word_req   (word_req),
    .word_pos   (word_pos),
    .score      (score),
    .lives      (lives),
    .time_left  (time_left)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          req_seen = 0;
  int          req_mark;
  exp_t        exp_q[$];
  logic [19:0] next_word;
  bit          load_word = 1'b0;

  // Reference model: game phase plus elapsed cycles in the current word window.
  int m_phase, m_idx, m_score, m_lives, m_tl, m_elapsed;
  bit m_zero;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] rand_word();
    logic [19:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) w = {w[14:0], 5'($urandom_range(0, 25))};
    return w;
  endfunction

  function automatic int letter(input logic [19:0] w, input int i);
    logic [19:0] s;
    s = w >> (5 * (3 - i));
    return int'(s[4:0]);
  endfunction

  task automatic model_reset();
    m_phase   = PH_IDLE;
    m_idx     = 0;
    m_score   = 0;
    m_lives   = ML;
    m_tl      = WT;
    m_elapsed = 0;
    m_zero    = 1'b0;
  endtask

  task automatic model_step(input bit st, input bit kv, input int ch,
                            input logic [19:0] tw, output exp_t e);
    bit req;
    req = 1'b0;
    case (m_phase)
      PH_IDLE: begin
        if (st) begin
          m_phase = PH_PLAY; m_score = 0; m_lives = ML; m_idx = 0;
          m_elapsed = 0; m_zero = 1'b0; m_tl = WT; req = 1'b1;
        end
      end
      PH_PLAY: begin
        if (!m_zero && m_elapsed == WT * T - 1) begin
          m_lives--; m_idx = 0; m_tl = 0; m_zero = 1'b1; m_elapsed = 0;
          if (m_lives == 0) m_phase = PH_OVER;
          else req = 1'b1;
        end else begin
          m_elapsed++;
          m_zero = 1'b0;
          m_tl   = WT - m_elapsed / T;
          if (kv) begin
            if (ch == letter(tw, m_idx)) begin
              if (m_idx < 3) m_idx++;
              else begin
                m_score   = (m_score < 255) ? m_score + 1 : 255;
                m_idx     = 0;
                m_elapsed = 0;
                m_tl      = WT;
                req       = 1'b1;
              end
            end else begin
              m_lives--; m_idx = 0;
              if (m_lives == 0) m_phase = PH_OVER;
            end
          end
        end
      end
      default: begin
        if (st) m_phase = PH_IDLE;
      end
    endcase
    e.req   = req;
    e.pos   = (m_phase == PH_IDLE) ? 5 : (m_phase == PH_OVER) ? 4 : m_idx;
    e.score = m_score;
    e.lives = m_lives;
    e.tl    = m_tl;
  endtask

  // One stimulus cycle: drive inputs at the falling edge and queue the expectation.
  task automatic drive_cycle(input bit st, input bit kv, input int kc);
    exp_t e;
    int   ch;
    @(negedge clk);
    if (load_word) begin
      target_word = next_word;
      next_word   = rand_word();
      load_word   = 1'b0;
    end
    ch = kc;
    if (kc == KEY_HIT)  ch = letter(target_word, m_idx);
    if (kc == KEY_MISS) ch = (letter(target_word, m_idx) + 1) % 26;
    start     = st;
    key_valid = kv;
    key_char  = 5'(ch);
    model_step(st, kv, ch, target_word, e);
    exp_q.push_back(e);
    if (e.req) load_word = 1'b1;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_word_req"},  word_req,  0);
    check({tag, "_word_pos"},  word_pos,  5);
    check({tag, "_score"},     score,     0);
    check({tag, "_lives"},     lives,     ML);
    check({tag, "_time_left"}, time_left, WT);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (word_req === 1'b1) req_seen++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("mon_word_req",  word_req,  e.req);
        check("mon_word_pos",  word_pos,  e.pos);
        check("mon_score",     score,     e.score);
        check("mon_lives",     lives,     e.lives);
        check("mon_time_left", time_left, e.tl);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    target_word = rand_word();
    next_word   = CATS;
    model_reset();

    // Reset and start.
    #2 rst_n = 1'b0;
    #1 check_reset_values("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req_mark = req_seen;
    drive_cycle(1'b1, 1'b0, 0);
    settle();
    check("s1_word_pos",  word_pos,  0);
    check("s1_lives",     lives,     3);
    check("s1_score",     score,     0);
    check("s1_time_left", time_left, 3);
    check("s1_req_count", req_seen - req_mark, 1);

    // Full hit on CATS.
    req_mark = req_seen;
    drive_cycle(1'b0, 1'b1, 2);
    drive_cycle(1'b0, 1'b1, 0);
    drive_cycle(1'b0, 1'b1, 19);
    next_word = CATS;
    drive_cycle(1'b0, 1'b1, 18);
    settle();
    check("s2_score",     score,     1);
    check("s2_word_pos",  word_pos,  0);
    check("s2_time_left", time_left, 3);
    check("s2_req_count", req_seen - req_mark, 1);

    // Miss: C then X.
    req_mark = req_seen;
    drive_cycle(1'b0, 1'b1, 2);
    drive_cycle(1'b0, 1'b1, 23);
    settle();
    check("s3_lives",     lives,    2);
    check("s3_word_pos",  word_pos, 0);
    check("s3_req_count", req_seen - req_mark, 0);

    // Two more misses end the game; start returns to the start screen.
    drive_cycle(1'b0, 1'b1, KEY_MISS);
    drive_cycle(1'b0, 1'b1, KEY_MISS);
    settle();
    check("miss_over_word_pos", word_pos, 4);
    check("miss_over_lives",    lives,    0);
    drive_cycle(1'b1, 1'b0, 0);
    settle();
    check("miss_over_idle_pos", word_pos, 5);

    // Timeouts to game over with no keys.
    drive_cycle(1'b1, 1'b0, 0);
    settle();
    req_mark = req_seen;
    repeat (90) drive_cycle(1'b0, 1'b0, 0);
    settle();
    check("s4_req_count", req_seen - req_mark, 2);
    check("s4_lives",     lives,     0);
    check("s4_word_pos",  word_pos,  4);
    check("s4_time_left", time_left, 0);
    drive_cycle(1'b1, 1'b0, 0);
    settle();
    check("s4_idle_pos", word_pos, 5);

    // Final letter lands in the timeout cycle.
    drive_cycle(1'b1, 1'b0, 0);
    repeat (3) drive_cycle(1'b0, 1'b1, KEY_HIT);
    repeat (26) drive_cycle(1'b0, 1'b0, 0);
    req_mark = req_seen;
    drive_cycle(1'b0, 1'b1, KEY_HIT);
    settle();
    check("s5_lives",     lives,    2);
    check("s5_score",     score,    0);
    check("s5_word_pos",  word_pos, 0);
    check("s5_req_count", req_seen - req_mark, 1);

    // Score saturation over 256 completed words.
    for (int w = 0; w < 256; w++) repeat (4) drive_cycle(1'b0, 1'b1, KEY_HIT);
    settle();
    check("s6_score_sat", score, 255);

    // Asynchronous reset between edges in the middle of a round.
    start     = 1'b0;
    key_valid = 1'b0;
    #1 rst_n  = 1'b0;
    #1 check_reset_values("s6_async");
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;

    // Randomized play, alternating busy and quiet stretches to provoke timeouts.
    for (int n = 0; n < 3000; n++) begin
      int r;
      int kc;
      bit kv;
      bit quiet;
      quiet = ((n / 400) % 2) == 1;
      r     = int'($urandom_range(0, 99));
      kv    = quiet ? (r < 2) : (r < 55);
      kc    = (r % 10 < 8) ? KEY_HIT : ((r % 10 == 8) ? KEY_MISS : int'($urandom_range(0, 25)));
      drive_cycle($urandom_range(0, 99) < 4, kv, kc);
    end
    settle();
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
